decode: RTL and testbench

DECODE -- requirements
Module: decode

---
 rtl/core_pkg.sv | 52 +++++
 rtl/decode_if.sv | 37 +++
 rtl/inst_field_decode.sv | 26 ++
 rtl/decode.sv | 111 +++++++++++
 tb/tb_decode.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/core_pkg.sv
// Shared decode definitions: instruction class codes, field positions,
// the all-NOP bundle constant and the decoded-slot record.
package core_pkg;

   localparam int CLS_MSB = 31;
   localparam int CLS_LSB = 29;
   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RD_MSB  = 25;
   localparam int RD_LSB  = 21;
   localparam int RS1_MSB = 20;
   localparam int RS1_LSB = 16;
   localparam int RS2_MSB = 15;
   localparam int RS2_LSB = 11;
   localparam int IMM_MSB = 15;
   localparam int IMM_LSB = 0;

   localparam logic [2:0] CLS_ALU    = 3'b000;
   localparam logic [2:0] CLS_ALUI   = 3'b001;
   localparam logic [2:0] CLS_LOAD   = 3'b010;
   localparam logic [2:0] CLS_STORE  = 3'b011;
   localparam logic [2:0] CLS_BRANCH = 3'b100;
   localparam logic [2:0] CLS_NOP    = 3'b111;

   localparam logic [31:0] NOP_INST   = {CLS_NOP, 29'b0};
   localparam logic [63:0] NOP_BUNDLE = {NOP_INST, NOP_INST};

   typedef enum logic {
      NORMAL = 1'b0,
      SECOND = 1'b1
   } dec_state_e;

   typedef struct packed {
      logic        valid;
      logic [5:0]  op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
      logic [31:0] pc;
   } dec_slot_t;

   function automatic logic class_writes_rd(input logic [2:0] cls);
      return (cls == CLS_ALU) || (cls == CLS_ALUI) || (cls == CLS_LOAD);
   endfunction

   // Reserved class codes behave exactly like the explicit NOP class.
   function automatic logic class_is_real(input logic [2:0] cls);
      return class_writes_rd(cls) || (cls == CLS_STORE) || (cls == CLS_BRANCH);
   endfunction

endpackage

// File: rtl/decode_if.sv
// Bundle-in / decoded-slots-out signal group between fetch, decode and issue.
interface decode_if;

   logic [63:0] inst_in;
   logic [31:0] inst_pc;
   logic        interlock;
   logic        flush;
   logic        fetch_stall;
   logic [1:0]  dec_valid;
   logic [5:0]  d0_op;
   logic [4:0]  d0_rd;
   logic [4:0]  d0_rs1;
   logic [4:0]  d0_rs2;
   logic [31:0] d0_imm;
   logic [31:0] d0_pc;
   logic [5:0]  d1_op;
   logic [4:0]  d1_rd;
   logic [4:0]  d1_rs1;
   logic [4:0]  d1_rs2;
   logic [31:0] d1_imm;
   logic [31:0] d1_pc;

   modport master (
      output inst_in, inst_pc, interlock, flush,
      input  fetch_stall, dec_valid,
             d0_op, d0_rd, d0_rs1, d0_rs2, d0_imm, d0_pc,
             d1_op, d1_rd, d1_rs1, d1_rs2, d1_imm, d1_pc
   );

   modport slave (
      input  inst_in, inst_pc, interlock, flush,
      output fetch_stall, dec_valid,
             d0_op, d0_rd, d0_rs1, d0_rs2, d0_imm, d0_pc,
             d1_op, d1_rd, d1_rs1, d1_rs2, d1_imm, d1_pc
   );

endinterface

// File: rtl/inst_field_decode.sv
// Combinational field extraction for one 32-bit instruction slot.
module inst_field_decode
   import core_pkg::*;
(
   input  logic [31:0] inst,
   input  logic [31:0] pc,
   output dec_slot_t   slot,
   output logic        writes_rd
);

   logic [2:0] cls;
   assign cls = inst[CLS_MSB:CLS_LSB];

   always_comb begin
      slot       = '0;
      slot.valid = class_is_real(cls);
      slot.op    = inst[OP_MSB:OP_LSB];
      slot.rd    = inst[RD_MSB:RD_LSB];
      slot.rs1   = inst[RS1_MSB:RS1_LSB];
      slot.rs2   = inst[RS2_MSB:RS2_LSB];
      slot.imm   = {{16{inst[IMM_MSB]}}, inst[IMM_MSB:IMM_LSB]};
      slot.pc    = pc;
      writes_rd  = class_writes_rd(cls);
   end

endmodule

// File: rtl/decode.sv
// Two-slot decode stage. Define DECODE_SPLIT_EN to split intra-bundle
// dependent pairs over two cycles; otherwise both slots always issue together.
module decode
   import core_pkg::*;
(
   input  logic    clk,
   input  logic    rstn,
   decode_if.slave dif
);

`ifdef DECODE_SPLIT_EN
   localparam logic SPLIT_EN = 1'b1;
`else
   localparam logic SPLIT_EN = 1'b0;
`endif

   dec_slot_t  dec0, dec1;
   logic       wr0, wr1;
   logic [31:0] pc1;
   logic       hazard;

   dec_state_e state, state_nxt;
   dec_slot_t  slot0_q, slot0_nxt;
   dec_slot_t  slot1_q, slot1_nxt;
   dec_slot_t  saved_q, saved_nxt;

   assign pc1 = dif.inst_pc + 32'd4;

   inst_field_decode u_slot0 (
      .inst      (dif.inst_in[63:32]),
      .pc        (dif.inst_pc),
      .slot      (dec0),
      .writes_rd (wr0)
   );

   inst_field_decode u_slot1 (
      .inst      (dif.inst_in[31:0]),
      .pc        (pc1),
      .slot      (dec1),
      .writes_rd (wr1)
   );

   // Slot1 depends on slot0's destination: read-after-write or write-after-write.
   assign hazard = SPLIT_EN && dec0.valid && dec1.valid && wr0 && (dec0.rd != 5'd0) &&
                   ((dec1.rs1 == dec0.rd) || (dec1.rs2 == dec0.rd) ||
                    (wr1 && (dec1.rd == dec0.rd)));

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state   <= NORMAL;
         slot0_q <= '0;
         slot1_q <= '0;
         saved_q <= '0;
      end else begin
         state   <= state_nxt;
         slot0_q <= slot0_nxt;
         slot1_q <= slot1_nxt;
         saved_q <= saved_nxt;
      end
   end

   // Flush outranks interlock, which in turn freezes the whole stage.
   always_comb begin
      state_nxt = state;
      slot0_nxt = slot0_q;
      slot1_nxt = slot1_q;
      saved_nxt = saved_q;
      if (dif.flush) begin
         state_nxt       = NORMAL;
         slot0_nxt.valid = 1'b0;
         slot1_nxt.valid = 1'b0;
         saved_nxt       = '0;
      end else if (!dif.interlock) begin
         case (state)
            NORMAL: begin
               slot0_nxt = dec0;
               if (hazard) begin
                  slot1_nxt = '0;
                  saved_nxt = dec1;
                  state_nxt = SECOND;
               end else begin
                  slot1_nxt = dec1;
               end
            end
            SECOND: begin
               slot0_nxt = saved_q;
               slot1_nxt = '0;
               saved_nxt = '0;
               state_nxt = NORMAL;
            end
            default: state_nxt = NORMAL;
         endcase
      end
   end

   assign dif.fetch_stall = SPLIT_EN && (state == SECOND);
   assign dif.dec_valid   = {slot1_q.valid, slot0_q.valid};
   assign dif.d0_op  = slot0_q.op;
   assign dif.d0_rd  = slot0_q.rd;
   assign dif.d0_rs1 = slot0_q.rs1;
   assign dif.d0_rs2 = slot0_q.rs2;
   assign dif.d0_imm = slot0_q.imm;
   assign dif.d0_pc  = slot0_q.pc;
   assign dif.d1_op  = slot1_q.op;
   assign dif.d1_rd  = slot1_q.rd;
   assign dif.d1_rs1 = slot1_q.rs1;
   assign dif.d1_rs2 = slot1_q.rs2;
   assign dif.d1_imm = slot1_q.imm;
   assign dif.d1_pc  = slot1_q.pc;

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for decode: vector table plus hand-written
// split / interlock / flush / reset sequences (split ones need DECODE_SPLIT_EN).
module tb_decode;

   logic clk;
   logic rstn;
   int   n_compared;
   int   n_mismatched;

   decode_if dif ();

   decode dut (
      .clk  (clk),
      .rstn (rstn),
      .dif  (dif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string       name;
      logic [63:0] inst;
      logic [31:0] pc;
      logic [1:0]  exp_valid;
      logic [5:0]  exp_d0_op;
      logic [4:0]  exp_d0_rd;
      logic [31:0] exp_d0_imm;
      logic [31:0] exp_d0_pc;
      logic [4:0]  exp_d1_rd;
      logic [31:0] exp_d1_imm;
      logic [31:0] exp_d1_pc;
   } vec_t;

   localparam logic [31:0] TB_NOP = 32'hE000_0000;

   function automatic logic [31:0] r_inst(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2);
      return {op, rd, rs1, rs2, 11'b0};
   endfunction

   function automatic logic [31:0] i_inst(input logic [5:0] op, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [15:0] imm);
      return {op, rd, rs1, imm};
   endfunction

   task automatic apply_stimulus(input logic [63:0] inst, input logic [31:0] pc,
                                 input logic ilk, input logic fl);
      dif.inst_in   = inst;
      dif.inst_pc   = pc;
      dif.interlock = ilk;
      dif.flush     = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   vec_t vecs[7];

   initial begin
      n_compared   = 0;
      n_mismatched = 0;

      vecs[0] = '{"nop_bundle", {TB_NOP, TB_NOP}, 32'h0000_0000, 2'b00,
                  6'h00, 5'd0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0};
      vecs[1] = '{"add_pair", {r_inst(6'h00, 5'd3, 5'd1, 5'd2), r_inst(6'h00, 5'd4, 5'd5, 5'd6)},
                  32'h0000_0010, 2'b11,
                  6'h00, 5'd3, 32'h0000_1000, 32'h0000_0010, 5'd4, 32'h0000_3000, 32'h0000_0014};
      vecs[2] = '{"rd_r0_no_split", {r_inst(6'h00, 5'd0, 5'd1, 5'd2), r_inst(6'h00, 5'd4, 5'd0, 5'd6)},
                  32'h0000_0020, 2'b11,
                  6'h00, 5'd0, 32'h0000_1000, 32'h0000_0020, 5'd4, 32'h0000_3000, 32'h0000_0024};
      vecs[3] = '{"imm_sext_pc_wrap", {i_inst(6'h08, 5'd7, 5'd1, 16'h8000), i_inst(6'h10, 5'd9, 5'd2, 16'h0004)},
                  32'hFFFF_FFF8, 2'b11,
                  6'h08, 5'd7, 32'hFFFF_8000, 32'hFFFF_FFF8, 5'd9, 32'h0000_0004, 32'hFFFF_FFFC};
      vecs[4] = '{"store_branch", {i_inst(6'h18, 5'd5, 5'd6, 16'h0010), i_inst(6'h20, 5'd5, 5'd5, 16'hFFFC)},
                  32'h0000_0040, 2'b11,
                  6'h18, 5'd5, 32'h0000_0010, 32'h0000_0040, 5'd5, 32'hFFFF_FFFC, 32'h0000_0044};
      vecs[5] = '{"reserved_slot0", {i_inst(6'h28, 5'd1, 5'd1, 16'h0000), r_inst(6'h00, 5'd1, 5'd2, 5'd3)},
                  32'h0000_0080, 2'b10,
                  6'h00, 5'd0, 32'h0, 32'h0, 5'd1, 32'h0000_1800, 32'h0000_0084};
      vecs[6] = '{"reserved_slot1", {r_inst(6'h00, 5'd2, 5'd2, 5'd2), 32'hC000_0000},
                  32'h0000_0100, 2'b01,
                  6'h00, 5'd2, 32'h0000_1000, 32'h0000_0100, 5'd0, 32'h0, 32'h0};

      // Reset with a live bundle on the input: everything must read zero.
      rstn = 1'b0;
      apply_stimulus(vecs[1].inst, 32'h0000_0010, 1'b0, 1'b0);
      check_output("rst_valid", 32'(dif.dec_valid), 32'h0);
      check_output("rst_stall", 32'(dif.fetch_stall), 32'h0);
      check_output("rst_d0_pc", dif.d0_pc, 32'h0);
      check_output("rst_d1_pc", dif.d1_pc, 32'h0);
      check_output("rst_d0_imm", dif.d0_imm, 32'h0);
      check_output("rst_d1_rd", 32'(dif.d1_rd), 32'h0);
      rstn = 1'b1;

      for (int i = 0; i < 7; i++) begin
         apply_stimulus(vecs[i].inst, vecs[i].pc, 1'b0, 1'b0);
         check_output({vecs[i].name, "_valid"}, 32'(dif.dec_valid), 32'(vecs[i].exp_valid));
         check_output({vecs[i].name, "_stall"}, 32'(dif.fetch_stall), 32'h0);
         if (vecs[i].exp_valid[0]) begin
            check_output({vecs[i].name, "_d0_op"}, 32'(dif.d0_op), 32'(vecs[i].exp_d0_op));
            check_output({vecs[i].name, "_d0_rd"}, 32'(dif.d0_rd), 32'(vecs[i].exp_d0_rd));
            check_output({vecs[i].name, "_d0_imm"}, dif.d0_imm, vecs[i].exp_d0_imm);
            check_output({vecs[i].name, "_d0_pc"}, dif.d0_pc, vecs[i].exp_d0_pc);
         end
         if (vecs[i].exp_valid[1]) begin
            check_output({vecs[i].name, "_d1_rd"}, 32'(dif.d1_rd), 32'(vecs[i].exp_d1_rd));
            check_output({vecs[i].name, "_d1_imm"}, dif.d1_imm, vecs[i].exp_d1_imm);
            check_output({vecs[i].name, "_d1_pc"}, dif.d1_pc, vecs[i].exp_d1_pc);
         end
      end

      // Interlock in NORMAL holds the previous outputs and ignores the new bundle.
      apply_stimulus(vecs[1].inst, 32'h0000_0010, 1'b0, 1'b0);
      for (int k = 0; k < 2; k++) begin
         apply_stimulus(vecs[4].inst, 32'h0000_0040, 1'b1, 1'b0);
         check_output("ilk_norm_valid", 32'(dif.dec_valid), 32'h3);
         check_output("ilk_norm_d0_pc", dif.d0_pc, 32'h0000_0010);
         check_output("ilk_norm_d1_rd", 32'(dif.d1_rd), 32'd4);
      end
      apply_stimulus(vecs[4].inst, 32'h0000_0040, 1'b0, 1'b0);
      check_output("ilk_norm_release_pc", dif.d0_pc, 32'h0000_0040);
      apply_stimulus(vecs[1].inst, 32'h0000_0010, 1'b1, 1'b1);
      check_output("flush_norm_valid", 32'(dif.dec_valid), 32'h0);

`ifdef DECODE_SPLIT_EN
      // RAW split: add r3,r1,r2 | add r4,r3,r6 at 0x20.
      apply_stimulus({r_inst(6'h00, 5'd3, 5'd1, 5'd2), r_inst(6'h00, 5'd4, 5'd3, 5'd6)},
                     32'h0000_0020, 1'b0, 1'b0);
      check_output("split1_valid", 32'(dif.dec_valid), 32'h1);
      check_output("split1_d0_pc", dif.d0_pc, 32'h0000_0020);
      check_output("split1_stall", 32'(dif.fetch_stall), 32'h1);
      apply_stimulus({TB_NOP, TB_NOP}, 32'h0000_0020, 1'b0, 1'b0);
      check_output("split2_valid", 32'(dif.dec_valid), 32'h1);
      check_output("split2_d0_pc", dif.d0_pc, 32'h0000_0024);
      check_output("split2_d0_rs1", 32'(dif.d0_rs1), 32'd3);
      check_output("split2_d0_rd", 32'(dif.d0_rd), 32'd4);
      check_output("split2_stall", 32'(dif.fetch_stall), 32'h0);
      apply_stimulus({TB_NOP, TB_NOP}, 32'h0000_0028, 1'b0, 1'b0);
      check_output("split3_valid", 32'(dif.dec_valid), 32'h0);

      // WAW split held three cycles by interlock while in SECOND.
      apply_stimulus({r_inst(6'h00, 5'd3, 5'd1, 5'd2), r_inst(6'h00, 5'd3, 5'd7, 5'd8)},
                     32'h0000_0030, 1'b0, 1'b0);
      check_output("waw_stall", 32'(dif.fetch_stall), 32'h1);
      for (int k = 0; k < 3; k++) begin
         apply_stimulus({r_inst(6'h00, 5'd3, 5'd1, 5'd2), r_inst(6'h00, 5'd3, 5'd7, 5'd8)},
                        32'h0000_0030, 1'b1, 1'b0);
         check_output("ilk_sec_valid", 32'(dif.dec_valid), 32'h1);
         check_output("ilk_sec_d0_pc", dif.d0_pc, 32'h0000_0030);
         check_output("ilk_sec_stall", 32'(dif.fetch_stall), 32'h1);
      end
      apply_stimulus({r_inst(6'h00, 5'd3, 5'd1, 5'd2), r_inst(6'h00, 5'd3, 5'd7, 5'd8)},
                     32'h0000_0030, 1'b0, 1'b0);
      check_output("ilk_rel_d0_pc", dif.d0_pc, 32'h0000_0034);
      check_output("ilk_rel_d0_rs1", 32'(dif.d0_rs1), 32'd7);
      check_output("ilk_rel_stall", 32'(dif.fetch_stall), 32'h0);

      // Flush (with interlock also high) in SECOND drops the saved slot.
      apply_stimulus({r_inst(6'h00, 5'd5, 5'd1, 5'd2), r_inst(6'h00, 5'd6, 5'd1, 5'd5)},
                     32'h0000_0050, 1'b0, 1'b0);
      check_output("fl_pre_stall", 32'(dif.fetch_stall), 32'h1);
      apply_stimulus({TB_NOP, TB_NOP}, 32'h0000_0050, 1'b1, 1'b1);
      check_output("fl_sec_valid", 32'(dif.dec_valid), 32'h0);
      check_output("fl_sec_stall", 32'(dif.fetch_stall), 32'h0);
      apply_stimulus({TB_NOP, TB_NOP}, 32'h0000_0058, 1'b0, 1'b0);
      check_output("fl_after_valid", 32'(dif.dec_valid), 32'h0);
      apply_stimulus({r_inst(6'h00, 5'd10, 5'd1, 5'd2), r_inst(6'h00, 5'd11, 5'd1, 5'd2)},
                     32'h0000_0060, 1'b0, 1'b0);
      check_output("fl_resume_valid", 32'(dif.dec_valid), 32'h3);
      check_output("fl_resume_d0_pc", dif.d0_pc, 32'h0000_0060);

      // Reset in SECOND discards the saved instruction.
      apply_stimulus({r_inst(6'h00, 5'd5, 5'd1, 5'd2), r_inst(6'h00, 5'd6, 5'd5, 5'd1)},
                     32'h0000_0070, 1'b0, 1'b0);
      check_output("rs_pre_stall", 32'(dif.fetch_stall), 32'h1);
      rstn = 1'b0;
      apply_stimulus({TB_NOP, TB_NOP}, 32'h0000_0070, 1'b0, 1'b0);
      check_output("rs_sec_valid", 32'(dif.dec_valid), 32'h0);
      check_output("rs_sec_stall", 32'(dif.fetch_stall), 32'h0);
      check_output("rs_sec_d0_pc", dif.d0_pc, 32'h0);
      rstn = 1'b1;
      apply_stimulus({TB_NOP, TB_NOP}, 32'h0000_0078, 1'b0, 1'b0);
      check_output("rs_after_valid", 32'(dif.dec_valid), 32'h0);
      check_output("rs_after_stall", 32'(dif.fetch_stall), 32'h0);
`else
      // Without splitting, a dependent pair still issues together.
      apply_stimulus({r_inst(6'h00, 5'd3, 5'd1, 5'd2), r_inst(6'h00, 5'd4, 5'd3, 5'd6)},
                     32'h0000_0020, 1'b0, 1'b0);
      check_output("nosplit_valid", 32'(dif.dec_valid), 32'h3);
      check_output("nosplit_d1_pc", dif.d1_pc, 32'h0000_0024);
      check_output("nosplit_d1_rs1", 32'(dif.d1_rs1), 32'd3);
      check_output("nosplit_stall", 32'(dif.fetch_stall), 32'h0);
      apply_stimulus({TB_NOP, TB_NOP}, 32'h0000_0028, 1'b0, 1'b0);
      check_output("nosplit_next_valid", 32'(dif.dec_valid), 32'h0);
      check_output("nosplit_next_stall", 32'(dif.fetch_stall), 32'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
